// File: rtl/md_ctrl_if.sv
// Pipeline-facing bundle of the multiply/divide unit: E-stage request,
// D-stage hazard query, and the HI/LO/busy/stall results.
interface md_ctrl_if;
   logic [2:0]  MD_op;
   logic        start;
   logic        flush;
   logic [31:0] A;
   logic [31:0] B;
   logic        MD_use_D;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        busy;
   logic        stall;

   modport master (
      output MD_op, start, flush, A, B, MD_use_D,
      input  HI, LO, busy, stall
   );

   modport slave (
      input  MD_op, start, flush, A, B, MD_use_D,
      output HI, LO, busy, stall
   );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide unit owning HI/LO, with a hazard stall request.
// Build option: define MD_DIVZERO_HOLD_EN to leave HI/LO untouched on divide-by-zero.
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   md_ctrl_if.slave   md
);

   typedef enum logic {IDLE, BUSY} state_t;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_t;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   state_t      state;
   logic [3:0]  cnt;
   md_op_t      op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   md_op_t      op_in;
   logic        long_op;

   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_wr;

   assign op_in   = md_op_t'(md.MD_op);
   assign long_op = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                    (op_in == OP_DIV)  || (op_in == OP_DIVU);

   assign md.stall = md.MD_use_D & (md.busy | (md.start & ~md.flush & long_op));

   // Result is formed from the latched operands only, so A/B may change freely while busy.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      res_hi = '0;
      res_lo = '0;
      res_wr = 1'b1;
      case (op_q)
         OP_MULT:  {res_hi, res_lo} = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
         OP_MULTU: {res_hi, res_lo} = {32'd0, a_q} * {32'd0, b_q};
         OP_DIV, OP_DIVU: begin
            if (b_q == 32'd0) begin
`ifdef MD_DIVZERO_HOLD_EN
               res_wr = 1'b0;
`else
               res_hi = a_q;
               res_lo = 32'hFFFF_FFFF;
`endif
            end else if (op_q == OP_DIV && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
               // The only signed quotient that does not fit in 32 bits wraps back to itself.
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else if (op_q == OP_DIV) begin
               res_lo = $signed(a_q) / $signed(b_q);
               res_hi = $signed(a_q) % $signed(b_q);
            end else begin
               res_lo = a_q / b_q;
               res_hi = a_q % b_q;
            end
         end
         default: res_wr = 1'b0;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         md.busy <= 1'b0;
         md.HI   <= '0;
         md.LO   <= '0;
         op_q    <= OP_NONE;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (md.start && !md.flush) begin
                  case (op_in)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        state   <= BUSY;
                        md.busy <= 1'b1;
                        cnt     <= (op_in == OP_MULT || op_in == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                        op_q    <= op_in;
                        a_q     <= md.A;
                        b_q     <= md.B;
                     end
                     OP_MTHI: md.HI <= md.A;
                     OP_MTLO: md.LO <= md.A;
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  state   <= IDLE;
                  md.busy <= 1'b0;
                  if (res_wr) begin
                     md.HI <= res_hi;
                     md.LO <= res_lo;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
